soml_decision_fifo: RTL and testbench

Downstream stage of the SOML MinFinder. Once per 4-cycle constellation sweep it captures MinFinder's four minimum distances, four minimum indices and Rq. It Gray-maps the indices to 16-QAM bit pairs and sums the distances into a candidate metric. Results are buffered in a 4-entry show-ahead FIFO with a valid/ready output handshake toward the bit sink.

---
 rtl/soml_decision_fifo_if.sv | 45 ++++
 rtl/soml_decision_fifo.sv | 166 ++++++++++++++++
 tb/tb_soml_decision_fifo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soml_decision_fifo_if.sv
// Signal bundle linking the SOML MinFinder, the decision FIFO and the bit sink.
// The slave side is the FIFO; the master side is whatever drives it (MinFinder plus sink).
interface soml_decision_fifo_if #(
    parameter int N = 32
);
    logic         sweep_valid;
    logic [N-1:0] min_dI1;
    logic [N-1:0] min_dQ1;
    logic [N-1:0] min_dI2;
    logic [N-1:0] min_dQ2;
    logic [2:0]   min_idx_dI1;
    logic [2:0]   min_idx_dQ1;
    logic [2:0]   min_idx_dI2;
    logic [2:0]   min_idx_dQ2;
    logic [N-1:0] Rq;

    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_bits;
    logic [N+1:0] out_metric;
    logic [N-1:0] out_rq;
    logic         out_err;
    logic [7:0]   drop_cnt;
    logic         overflow;

    modport slave (
        input  sweep_valid,
        input  min_dI1, min_dQ1, min_dI2, min_dQ2,
        input  min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2,
        input  Rq,
        input  out_ready,
        output out_valid, out_bits, out_metric, out_rq, out_err,
        output drop_cnt, overflow
    );

    modport master (
        output sweep_valid,
        output min_dI1, min_dQ1, min_dI2, min_dQ2,
        output min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2,
        output Rq,
        output out_ready,
        input  out_valid, out_bits, out_metric, out_rq, out_err,
        input  drop_cnt, overflow
    );
endinterface

// File: rtl/soml_decision_fifo.sv
// SOML decision stage: once per 4-cycle sweep, Gray-maps MinFinder indices, sums the
// four minimum distances and queues {bits, metric, Rq, err} in a show-ahead FIFO.
module soml_decision_fifo #(
    parameter int N     = 32,
    parameter int Q     = 22,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    soml_decision_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_PRIME,
        S_RUN
    } prime_state_e;

    typedef struct packed {
        logic [7:0]   bits;
        logic [N+1:0] metric;
        logic [N-1:0] rq;
        logic         err;
    } entry_t;

    // Q only documents the fixed-point format of distances and Rq; no rescaling is done here.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("soml_decision_fifo: Q must lie in [0, N)");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("soml_decision_fifo: DEPTH must be a power of two and at least 2");
    end

    prime_state_e  r_state;
    prime_state_e  w_state_next;
    logic [1:0]    r_phase;
    entry_t        r_mem [DEPTH];
    entry_t        r_head;
    entry_t        w_entry;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] r_count;
    logic [7:0]    r_drop_cnt;
    logic          r_overflow;
    logic          w_capture;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    function automatic logic [1:0] gray_map(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'b00;
            3'd1:    return 2'b01;
            3'd2:    return 2'b11;
            3'd3:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PRIME: if (r_phase == 2'd3) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_PRIME;
        endcase
    end

    always_comb begin
        w_entry        = '0;
        w_entry.bits   = {gray_map(bus.min_idx_dI1), gray_map(bus.min_idx_dQ1),
                          gray_map(bus.min_idx_dI2), gray_map(bus.min_idx_dQ2)};
        w_entry.metric = {2'b00, bus.min_dI1} + {2'b00, bus.min_dQ1}
                       + {2'b00, bus.min_dI2} + {2'b00, bus.min_dQ2};
        w_entry.rq     = bus.Rq;
        w_entry.err    = bus.min_idx_dI1[2] | bus.min_idx_dQ1[2]
                       | bus.min_idx_dI2[2] | bus.min_idx_dQ2[2];
    end

    assign w_capture = (r_phase == 2'd0) && (r_state == S_RUN) && bus.sweep_valid;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;
    assign w_rd_next = r_rd_ptr + AW'(1);

    // NOTE: the storage array is reset as well because its contents are tiny and reset must
    // leave every output at zero; larger FIFOs would leave the array unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered head copy: tracks the next head entry and holds the last one once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_push && (w_empty || (w_pop && r_count == CW'(1)))) begin
            r_head <= w_entry;
        end else if (w_pop && r_count > CW'(1)) begin
            r_head <= r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.out_valid  = !w_empty;
    assign bus.out_bits   = r_head.bits;
    assign bus.out_metric = r_head.metric;
    assign bus.out_rq     = r_head.rq;
    assign bus.out_err    = r_head.err;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_soml_decision_fifo.sv
// Self-checking bench for soml_decision_fifo: directed cases from the block's rules plus
// randomized traffic, all compared against a queue-based reference model.
module tb_soml_decision_fifo;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]   bits;
        logic [N+1:0] metric;
        logic [N-1:0] rq;
        logic         err;
    } exp_entry_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         edges    = 0;
    int         exp_drop = 0;
    logic       exp_ovf  = 1'b0;
    exp_entry_t model_q[$];

    soml_decision_fifo_if #(.N(N)) bus ();

    soml_decision_fifo #(.N(N), .Q(22), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Binary-reflected Gray code of a valid index; out-of-range indices map to 00.
    function automatic logic [1:0] gray_of(input int idx);
        int g;
        if (idx > 3) return 2'b00;
        g = idx ^ (idx >> 1);
        return g[1:0];
    endfunction

    function automatic exp_entry_t expected_from_inputs();
        exp_entry_t e;
        int         idx[4];
        longint     d[4];
        longint     sum;
        idx = '{int'(bus.min_idx_dI1), int'(bus.min_idx_dQ1), int'(bus.min_idx_dI2), int'(bus.min_idx_dQ2)};
        d   = '{longint'(bus.min_dI1), longint'(bus.min_dQ1), longint'(bus.min_dI2), longint'(bus.min_dQ2)};
        e   = '0;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            e.bits = {e.bits[5:0], gray_of(idx[i])};
            if (idx[i] > 3) e.err = 1'b1;
            sum += d[i];
        end
        e.metric = (N + 2)'(sum);
        e.rq     = bus.Rq;
        return e;
    endfunction

    function automatic bit next_is_capture();
        int k;
        k = edges + 1;
        return (k >= 5) && ((k % 4) == 1);
    endfunction

    // One clock edge: predict its effect, advance, then compare on the falling edge.
    task automatic step();
        bit         pop;
        bit         cap;
        exp_entry_t e;
        pop = (model_q.size() != 0) && (bus.out_ready === 1'b1);
        cap = next_is_capture() && (bus.sweep_valid === 1'b1);
        e   = expected_from_inputs();
        @(posedge clk);
        edges++;
        if (pop) void'(model_q.pop_front());
        if (cap) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(e);
            end else begin
                if (exp_drop < 255) exp_drop++;
                exp_ovf = 1'b1;
            end
        end
        @(negedge clk);
        check("out_valid", 64'(bus.out_valid), 64'(model_q.size() != 0));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
        check("overflow", 64'(bus.overflow), 64'(exp_ovf));
        if (model_q.size() != 0) begin
            check("head_bits", 64'(bus.out_bits), 64'(model_q[0].bits));
            check("head_metric", 64'(bus.out_metric), 64'(model_q[0].metric));
            check("head_rq", 64'(bus.out_rq), 64'(model_q[0].rq));
            check("head_err", 64'(bus.out_err), 64'(model_q[0].err));
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic step_to_capture();
        for (int i = 0; i < 8 && !next_is_capture(); i++) step();
        check("capture_alignment", 64'(next_is_capture()), 64'd1);
    endtask

    task automatic drive_fixed(input logic sv, input logic [N-1:0] d, input logic [2:0] i1,
                               input logic [2:0] q1, input logic [2:0] i2, input logic [2:0] q2,
                               input logic [N-1:0] rq);
        bus.sweep_valid = sv;
        bus.min_dI1 = d;  bus.min_dQ1 = d;  bus.min_dI2 = d;  bus.min_dQ2 = d;
        bus.min_idx_dI1 = i1;  bus.min_idx_dQ1 = q1;
        bus.min_idx_dI2 = i2;  bus.min_idx_dQ2 = q2;
        bus.Rq = rq;
    endtask

    task automatic drive_random(input logic sv);
        bus.sweep_valid = sv;
        bus.min_dI1 = $urandom();  bus.min_dQ1 = $urandom();
        bus.min_dI2 = $urandom();  bus.min_dQ2 = $urandom();
        bus.min_idx_dI1 = 3'($urandom_range(0, 7));
        bus.min_idx_dQ1 = 3'($urandom_range(0, 7));
        bus.min_idx_dI2 = 3'($urandom_range(0, 7));
        bus.min_idx_dQ2 = 3'($urandom_range(0, 7));
        bus.Rq = $urandom();
    endtask

    task automatic check_reset_outputs(input string phase_tag);
        check({phase_tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({phase_tag, "_out_bits"}, 64'(bus.out_bits), 64'd0);
        check({phase_tag, "_out_metric"}, 64'(bus.out_metric), 64'd0);
        check({phase_tag, "_out_rq"}, 64'(bus.out_rq), 64'd0);
        check({phase_tag, "_out_err"}, 64'(bus.out_err), 64'd0);
        check({phase_tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'd0);
        check({phase_tag, "_overflow"}, 64'(bus.overflow), 64'd0);
    endtask

    task automatic clear_model();
        model_q.delete();
        edges    = 0;
        exp_drop = 0;
        exp_ovf  = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive_fixed(1'b0, '0, 3'd0, 3'd0, 3'd0, 3'd0, '0);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single capture: first capture lands on the 5th edge after release.
        drive_fixed(1'b1, 32'h0010_0000, 3'd2, 3'd2, 3'd2, 3'd2, 32'h0040_0000);
        step_n(4);
        check("first_capture_not_before_edge5", 64'(bus.out_valid), 64'd0);
        step();
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_bits", 64'(bus.out_bits), 64'hFF);
        check("single_metric", 64'(bus.out_metric), 64'h0040_0000);
        check("single_rq", 64'(bus.out_rq), 64'h0040_0000);
        check("single_err", 64'(bus.out_err), 64'd0);
        bus.sweep_valid = 1'b0;
        bus.out_ready   = 1'b1;
        step();
        bus.out_ready   = 1'b0;

        // Gray mapping of each valid index.
        drive_fixed(1'b1, 32'h0000_1234, 3'd0, 3'd1, 3'd2, 3'd3, 32'h0000_0777);
        step_to_capture();
        step();
        bus.sweep_valid = 1'b0;
        check("gray_bits", 64'(bus.out_bits), 64'h1E);
        check("gray_err", 64'(bus.out_err), 64'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Out-of-range index maps to 00 and flags the entry.
        drive_fixed(1'b1, 32'h0000_0001, 3'd3, 3'd3, 3'd3, 3'd5, 32'h0000_0002);
        step_to_capture();
        step();
        bus.sweep_valid = 1'b0;
        check("invalid_bits", 64'(bus.out_bits), 64'hA8);
        check("invalid_err", 64'(bus.out_err), 64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Back-pressure: six sweeps into a 4-deep FIFO drop two.
        for (int s = 0; s < 6; s++) begin
            step_to_capture();
            drive_random(1'b1);
            step();
        end
        bus.sweep_valid = 1'b0;
        check("ovf_drop_cnt", 64'(bus.drop_cnt), 64'd2);
        check("ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.out_ready = 1'b1;
        step_n(3);
        check("ovf_valid_after_3_pops", 64'(bus.out_valid), 64'd1);
        step();
        check("ovf_empty_after_4_pops", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Full FIFO with a pop on the capture edge: no drop, new entry goes last.
        for (int s = 0; s < 4; s++) begin
            step_to_capture();
            drive_random(1'b1);
            step();
        end
        step_to_capture();
        drive_random(1'b1);
        bus.out_ready = 1'b1;
        step();
        bus.sweep_valid = 1'b0;
        check("fullpop_drop_unchanged", 64'(bus.drop_cnt), 64'd2);
        step_n(3);
        check("fullpop_count_kept", 64'(bus.out_valid), 64'd1);
        step();
        check("fullpop_drained", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // sweep_valid low on a capture edge pushes nothing.
        drive_random(1'b0);
        step_to_capture();
        step();
        check("no_sweep_no_push", 64'(bus.out_valid), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            drive_random(1'($urandom_range(0, 1)));
            bus.out_ready = ($urandom_range(0, 9) < 4);
            step();
        end

        // Mid-stream reset clears everything immediately; priming restarts.
        bus.out_ready = 1'b0;
        drive_random(1'b1);
        step_n(8);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        drive_fixed(1'b1, 32'h0000_0100, 3'd1, 3'd2, 3'd3, 3'd0, 32'h0000_0ABC);
        step_n(4);
        check("midreset_no_early_capture", 64'(bus.out_valid), 64'd0);
        step();
        check("midreset_capture_edge5", 64'(bus.out_valid), 64'd1);
        check("midreset_bits", 64'(bus.out_bits), 64'h78);
        check("midreset_metric", 64'(bus.out_metric), 64'h400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
